// File: rtl/noc_out_arbiter.sv
// Round-robin arbiter sharing one mesh output link between N requesters,
// with a single registered output stage (1-cycle latency, full throughput).
module noc_out_arbiter #(
  parameter int data_width  = 256,
  parameter int x_size      = 2,
  parameter int y_size      = 2,
  parameter int total_width = x_size + y_size + data_width,
  parameter int N           = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N-1:0]             i_valid,
  input  logic [N*total_width-1:0] i_data,
  output logic [N-1:0]             o_ready,
  output logic                     o_valid,
  output logic [total_width-1:0]   o_data,
  input  logic                     i_ready,
  output logic [N-1:0]             o_grant,
  output logic [15:0]              o_flit_count
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  // Handshake: a transfer happens on any edge where valid and ready are both
  // high; a sender keeps valid/data stable until it sees its ready high.

  logic [PW-1:0]          ptr;
  logic [PW-1:0]          win;
  logic                   found;
  logic                   load;
  logic [total_width-1:0] win_data;
  logic [PW-1:0]          ptr_next;

  assign load = ~o_valid | i_ready;

  // Cyclic search starting at ptr; first asserted requester wins.
  always_comb begin
    int cand;
    cand  = 0;
    found = 1'b0;
    win   = '0;
    for (int i = 0; i < N; i++) begin
      cand = int'(ptr) + i;
      if (cand >= N) cand = cand - N;
      if (!found && i_valid[cand]) begin
        found = 1'b1;
        win   = PW'(cand);
      end
    end
  end

  assign win_data = i_data[int'(win)*total_width +: total_width];
  assign ptr_next = (win == PW'(N-1)) ? '0 : win + PW'(1);

  always_comb begin
    o_ready = '0;
    if (!rst && load && found) o_ready[win] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      o_valid      <= 1'b0;
      o_data       <= '0;
      o_grant      <= '0;
      ptr          <= '0;
      o_flit_count <= '0;
    end else begin
      if (o_valid && i_ready) o_flit_count <= o_flit_count + 16'd1;
      if (load) begin
        if (found) begin
          o_valid      <= 1'b1;
          o_data       <= win_data;
          o_grant      <= '0;
          o_grant[win] <= 1'b1;
          ptr          <= ptr_next;
        end else begin
          // Idle: drop valid, keep last data so o_data never glitches.
          o_valid <= 1'b0;
          o_grant <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_noc_out_arbiter.sv
// Table-driven bench for noc_out_arbiter: per-cycle vectors plus a counter
// wrap and mid-transfer reset sequence.
module tb_noc_out_arbiter;

  localparam int TW = 260;
  localparam int N  = 3;

  typedef struct {
    logic        rst;
    logic [2:0]  v;
    logic        rdy;
    logic [2:0]  e_ready;
    logic        e_valid;
    logic [2:0]  e_grant;
    int          e_src;    // requester whose flit is expected in o_data, -1 = zero
    logic [15:0] e_cnt;
  } vec_t;

  logic              clk;
  logic              rst;
  logic [N-1:0]      i_valid;
  logic [N*TW-1:0]   i_data;
  logic [N-1:0]      o_ready;
  logic              o_valid;
  logic [TW-1:0]     o_data;
  logic              i_ready;
  logic [N-1:0]      o_grant;
  logic [15:0]       o_flit_count;

  int checks;
  int errors;
  vec_t tbl[$];

  noc_out_arbiter dut (
    .clk          (clk),
    .rst          (rst),
    .i_valid      (i_valid),
    .i_data       (i_data),
    .o_ready      (o_ready),
    .o_valid      (o_valid),
    .o_data       (o_data),
    .i_ready      (i_ready),
    .o_grant      (o_grant),
    .o_flit_count (o_flit_count)
  );

  // Clock/reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [TW-1:0] flit(input int k);
    logic [TW-1:0] f;
    f            = '0;
    f[7:0]       = 8'hA5;
    f[15:8]      = 8'(k);
    f[200 +: 8]  = 8'h5A ^ 8'(k);
    f[TW-1 -: 4] = 4'(k + 1);
    return f;
  endfunction

  function automatic vec_t mk(input logic r, input logic [2:0] v, input logic rdy,
                              input logic [2:0] er, input logic ev, input logic [2:0] eg,
                              input int es, input logic [15:0] ec);
    vec_t t;
    t.rst = r; t.v = v; t.rdy = rdy; t.e_ready = er; t.e_valid = ev;
    t.e_grant = eg; t.e_src = es; t.e_cnt = ec;
    return t;
  endfunction

  // Scoreboard compare
  task automatic chk(input string name, input logic [TW-1:0] act, input logic [TW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Driver: apply inputs at negedge, check o_ready before the edge and
  // registered outputs just after it.
  task automatic step(input vec_t t);
    logic [TW-1:0] ed;
    @(negedge clk);
    rst = t.rst; i_valid = t.v; i_ready = t.rdy;
    #1;
    chk("o_ready", TW'(o_ready), TW'(t.e_ready));
    @(posedge clk);
    #1;
    ed = (t.e_src < 0) ? '0 : flit(t.e_src);
    chk("o_valid", TW'(o_valid), TW'(t.e_valid));
    chk("o_grant", TW'(o_grant), TW'(t.e_grant));
    chk("o_data", o_data, ed);
    chk("o_flit_count", TW'(o_flit_count), TW'(t.e_cnt));
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    rst     = 1'b1;
    i_valid = '0;
    i_ready = 1'b0;
    for (int k = 0; k < N; k++) i_data[k*TW +: TW] = flit(k);

    //        rst v       rdy er      ev   eg      src cnt
    // reset with everyone requesting
    tbl.push_back(mk(1, 3'b111, 1, 3'b000, 0, 3'b000, -1, 16'd0));
    tbl.push_back(mk(1, 3'b111, 1, 3'b000, 0, 3'b000, -1, 16'd0));
    // single requester 2
    tbl.push_back(mk(0, 3'b100, 1, 3'b100, 1, 3'b100,  2, 16'd0));
    tbl.push_back(mk(0, 3'b100, 1, 3'b100, 1, 3'b100,  2, 16'd1));
    tbl.push_back(mk(0, 3'b100, 1, 3'b100, 1, 3'b100,  2, 16'd2));
    // reset, then all three contending
    tbl.push_back(mk(1, 3'b111, 1, 3'b000, 0, 3'b000, -1, 16'd0));
    tbl.push_back(mk(0, 3'b111, 1, 3'b001, 1, 3'b001,  0, 16'd0));
    tbl.push_back(mk(0, 3'b111, 1, 3'b010, 1, 3'b010,  1, 16'd1));
    tbl.push_back(mk(0, 3'b111, 1, 3'b100, 1, 3'b100,  2, 16'd2));
    tbl.push_back(mk(0, 3'b111, 1, 3'b001, 1, 3'b001,  0, 16'd3));
    tbl.push_back(mk(0, 3'b111, 1, 3'b010, 1, 3'b010,  1, 16'd4));
    tbl.push_back(mk(0, 3'b111, 1, 3'b100, 1, 3'b100,  2, 16'd5));
    tbl.push_back(mk(0, 3'b000, 1, 3'b000, 0, 3'b000,  2, 16'd6));
    // backpressure: load from requester 1, stall 5 cycles, then release
    tbl.push_back(mk(0, 3'b010, 1, 3'b010, 1, 3'b010,  1, 16'd6));
    for (int i = 0; i < 5; i++)
      tbl.push_back(mk(0, 3'b111, 0, 3'b000, 1, 3'b010, 1, 16'd6));
    tbl.push_back(mk(0, 3'b111, 1, 3'b100, 1, 3'b100,  2, 16'd7));
    // pointer skip: get ptr=1, then only requester 0, then all
    tbl.push_back(mk(0, 3'b001, 1, 3'b001, 1, 3'b001,  0, 16'd8));
    tbl.push_back(mk(0, 3'b001, 1, 3'b001, 1, 3'b001,  0, 16'd9));
    tbl.push_back(mk(0, 3'b111, 1, 3'b010, 1, 3'b010,  1, 16'd10));
    tbl.push_back(mk(0, 3'b000, 1, 3'b000, 0, 3'b000,  1, 16'd11));

    foreach (tbl[i]) step(tbl[i]);

    // Counter wrap: after reset, 0xFFFF contending cycles give 0xFFFE transfers.
    step(mk(1, 3'b111, 1, 3'b000, 0, 3'b000, -1, 16'd0));
    @(negedge clk);
    rst = 1'b0; i_valid = 3'b111; i_ready = 1'b1;
    repeat (16'hFFFF) @(posedge clk);
    #1;
    chk("wrap_pre_count", TW'(o_flit_count), TW'(16'hFFFE));
    chk("wrap_pre_grant", TW'(o_grant), TW'(3'b100));
    step(mk(0, 3'b111, 1, 3'b001, 1, 3'b001, 0, 16'hFFFF));
    step(mk(0, 3'b111, 1, 3'b010, 1, 3'b010, 1, 16'h0000));
    // Mid-transfer reset: stall, reset while full, then requester 0 wins.
    step(mk(0, 3'b111, 0, 3'b000, 1, 3'b010,  1, 16'h0000));
    step(mk(1, 3'b111, 0, 3'b000, 0, 3'b000, -1, 16'h0000));
    step(mk(0, 3'b111, 1, 3'b001, 1, 3'b001,  0, 16'h0000));
    step(mk(0, 3'b000, 1, 3'b000, 0, 3'b000,  0, 16'h0001));

    // Final report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
